// File: rtl/breakpoint_unit_multi.sv
// Multi-trigger hardware breakpoint unit: CSR-loaded triggers with exact/NAPOT/range
// matching, chaining, hit countdown, sticky hit flags and registered exception/debug pulses.
module breakpoint_unit_multi #(
  parameter int XLEN    = 32,
  parameter int NBP     = 4,
  parameter int MASKMAX = 4,
  parameter int CNT_W   = 8,
  localparam int IDX_W  = (NBP > 1) ? $clog2(NBP) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_wen,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [1:0]       cfg_sel,
  input  logic [XLEN-1:0]  cfg_wdata,
  output logic [XLEN-1:0]  cfg_rdata,
  input  logic             status_debug,
  input  logic [1:0]       status_prv,
  input  logic             pc_valid,
  input  logic [XLEN-1:0]  pc,
  input  logic             ea_valid,
  input  logic             ea_is_store,
  input  logic [XLEN-1:0]  ea,
  output logic             xcpt_if,
  output logic             xcpt_ld,
  output logic             xcpt_st,
  output logic             debug_if,
  output logic             debug_ld,
  output logic             debug_st,
  output logic [NBP-1:0]   hit_vec
);

  localparam int CTRL_W   = 12;
  localparam int B_R      = 0;
  localparam int B_W      = 1;
  localparam int B_X      = 2;
  localparam int B_U      = 3;
  localparam int B_M      = 6;
  localparam int B_TM     = 7;
  localparam int B_CHAIN  = 9;
  localparam int B_ACTION = 10;
  localparam int B_CNTEN  = 11;

  localparam logic [1:0] SEL_CTRL = 2'd0;
  localparam logic [1:0] SEL_ADDR = 2'd1;
  localparam logic [1:0] SEL_CNT  = 2'd2;

  localparam logic [1:0] TM_EXACT = 2'd0;
  localparam logic [1:0] TM_NAPOT = 2'd1;
  localparam logic [1:0] TM_GE    = 2'd2;

  logic [CTRL_W-1:0] ctrl_q [NBP];
  logic [XLEN-1:0]   addr_q [NBP];
  logic [CNT_W-1:0]  cnt_q  [NBP];

  logic             idx_ok;
  logic [NBP-1:0]   wr_hit;
  logic [NBP-1:0]   ctrl_wr;
  logic [NBP-1:0]   raw_if, raw_ld, raw_st;
  logic [NBP-1:0]   chain_eff, counting, action_vec;
  logic [NBP-1:0]   grp_if, grp_ld, grp_st, grp_any;
  logic [NBP-1:0]   fire_if, fire_ld, fire_st, fire_any;
  logic             dbg_if_d, dbg_ld_d, dbg_st_d;
  logic             xcpt_if_d, xcpt_ld_d, xcpt_st_d;

  // NAPOT mask grows through each trailing one of the trigger address, capped at MASKMAX bits.
  function automatic logic addr_match(input logic [1:0] tm, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] t);
    logic [XLEN-1:0] mask;
    logic            run;
    mask    = '0;
    mask[0] = 1'b1;
    run     = 1'b1;
    for (int k = 1; k < MASKMAX; k++) begin
      run     = run & t[k-1];
      mask[k] = run;
    end
    case (tm)
      TM_EXACT: addr_match = (a == t);
      TM_NAPOT: addr_match = ((~a | mask) == (~t | mask));
      TM_GE:    addr_match = (a >= t);
      default:  addr_match = (a < t);
    endcase
  endfunction

  assign idx_ok = ({1'b0, cfg_idx} < (IDX_W+1)'(NBP));

  always_comb begin
    wr_hit  = '0;
    ctrl_wr = '0;
    for (int i = 0; i < NBP; i++) begin
      wr_hit[i]  = cfg_wen && idx_ok && (cfg_idx == IDX_W'(i));
      ctrl_wr[i] = wr_hit[i] && (cfg_sel == SEL_CTRL);
    end
  end

  always_comb begin
    cfg_rdata = '0;
    if (idx_ok) begin
      case (cfg_sel)
        SEL_CTRL: cfg_rdata[CTRL_W-1:0] = ctrl_q[cfg_idx];
        SEL_ADDR: cfg_rdata             = addr_q[cfg_idx];
        SEL_CNT:  cfg_rdata[CNT_W-1:0]  = cnt_q[cfg_idx];
        default:  cfg_rdata             = '0;
      endcase
    end
  end

  always_comb begin
    logic [3:0] prv_bits;
    logic       base_ok;
    logic       ea_hit;
    raw_if     = '0;
    raw_ld     = '0;
    raw_st     = '0;
    chain_eff  = '0;
    counting   = '0;
    action_vec = '0;
    prv_bits   = '0;
    base_ok    = 1'b0;
    ea_hit     = 1'b0;
    for (int i = 0; i < NBP; i++) begin
      prv_bits  = ctrl_q[i][B_M:B_U];
      base_ok   = !status_debug && prv_bits[status_prv];
      ea_hit    = addr_match(ctrl_q[i][B_TM+1:B_TM], ea, addr_q[i]);
      raw_if[i] = base_ok && ctrl_q[i][B_X] && pc_valid &&
                  addr_match(ctrl_q[i][B_TM+1:B_TM], pc, addr_q[i]);
      raw_ld[i] = base_ok && ctrl_q[i][B_R] && ea_valid && !ea_is_store && ea_hit;
      raw_st[i] = base_ok && ctrl_q[i][B_W] && ea_valid && ea_is_store && ea_hit;
      chain_eff[i]  = (i == NBP-1) ? 1'b0 : ctrl_q[i][B_CHAIN];
      counting[i]   = ctrl_q[i][B_CNTEN] && (cnt_q[i] != '0);
      action_vec[i] = ctrl_q[i][B_ACTION];
    end
  end

  // Running AND across a chained run; only the terminal of each run reports the result.
  always_comb begin
    logic acc_if, acc_ld, acc_st, linked;
    grp_if = '0;
    grp_ld = '0;
    grp_st = '0;
    acc_if = 1'b0;
    acc_ld = 1'b0;
    acc_st = 1'b0;
    linked = 1'b0;
    for (int i = 0; i < NBP; i++) begin
      acc_if    = (linked ? acc_if : 1'b1) & raw_if[i];
      acc_ld    = (linked ? acc_ld : 1'b1) & raw_ld[i];
      acc_st    = (linked ? acc_st : 1'b1) & raw_st[i];
      grp_if[i] = acc_if & ~chain_eff[i];
      grp_ld[i] = acc_ld & ~chain_eff[i];
      grp_st[i] = acc_st & ~chain_eff[i];
      linked    = chain_eff[i];
    end
  end

  assign grp_any  = grp_if | grp_ld | grp_st;
  assign fire_if  = grp_if & ~counting;
  assign fire_ld  = grp_ld & ~counting;
  assign fire_st  = grp_st & ~counting;
  assign fire_any = fire_if | fire_ld | fire_st;

  assign dbg_if_d  = |(fire_if & action_vec);
  assign dbg_ld_d  = |(fire_ld & action_vec);
  assign dbg_st_d  = |(fire_st & action_vec);
  assign xcpt_if_d = |(fire_if & ~action_vec) & ~dbg_if_d;
  assign xcpt_ld_d = |(fire_ld & ~action_vec) & ~dbg_ld_d;
  assign xcpt_st_d = |(fire_st & ~action_vec) & ~dbg_st_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xcpt_if  <= 1'b0;
      xcpt_ld  <= 1'b0;
      xcpt_st  <= 1'b0;
      debug_if <= 1'b0;
      debug_ld <= 1'b0;
      debug_st <= 1'b0;
      hit_vec  <= '0;
    end else begin
      xcpt_if  <= xcpt_if_d;
      xcpt_ld  <= xcpt_ld_d;
      xcpt_st  <= xcpt_st_d;
      debug_if <= dbg_if_d;
      debug_ld <= dbg_ld_d;
      debug_st <= dbg_st_d;
      hit_vec  <= (hit_vec | fire_any) & ~ctrl_wr;
    end
  end

  // A CSR write to count overrides the countdown decrement in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NBP; i++) begin
        ctrl_q[i] <= '0;
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NBP; i++) begin
        if (ctrl_wr[i])
          ctrl_q[i] <= cfg_wdata[CTRL_W-1:0];
        if (wr_hit[i] && cfg_sel == SEL_ADDR)
          addr_q[i] <= cfg_wdata;
        if (wr_hit[i] && cfg_sel == SEL_CNT)
          cnt_q[i] <= cfg_wdata[CNT_W-1:0];
        else if (grp_any[i] && counting[i])
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_breakpoint_unit_multi.sv
// Bench for breakpoint_unit_multi: directed vector table, async reset sequence, and
// randomized traffic compared against a range/group-level reference model.
module tb_breakpoint_unit_multi;

  localparam int NBP     = 4;
  localparam int XLEN    = 32;
  localparam int MASKMAX = 4;
  localparam int CNT_W   = 8;

  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_DLD  = 6'b010000;
  localparam logic [5:0] P_DST  = 6'b001000;
  localparam logic [5:0] P_XIF  = 6'b000100;
  localparam logic [5:0] P_XLD  = 6'b000010;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            cfg_wen = 1'b0;
  logic [1:0]      cfg_idx = '0;
  logic [1:0]      cfg_sel = '0;
  logic [XLEN-1:0] cfg_wdata = '0;
  logic [XLEN-1:0] cfg_rdata;
  logic            status_debug = 1'b0;
  logic [1:0]      status_prv = 2'd3;
  logic            pc_valid = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic            ea_valid = 1'b0;
  logic            ea_is_store = 1'b0;
  logic [XLEN-1:0] ea = '0;
  logic            xcpt_if, xcpt_ld, xcpt_st, debug_if, debug_ld, debug_st;
  logic [NBP-1:0]  hit_vec;

  int checks   = 0;
  int failures = 0;

  breakpoint_unit_multi #(.XLEN(XLEN), .NBP(NBP), .MASKMAX(MASKMAX), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .cfg_wen(cfg_wen), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .status_debug(status_debug), .status_prv(status_prv),
    .pc_valid(pc_valid), .pc(pc),
    .ea_valid(ea_valid), .ea_is_store(ea_is_store), .ea(ea),
    .xcpt_if(xcpt_if), .xcpt_ld(xcpt_ld), .xcpt_st(xcpt_st),
    .debug_if(debug_if), .debug_ld(debug_ld), .debug_st(debug_st),
    .hit_vec(hit_vec)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        wen;
    logic [1:0]  idx;
    logic [1:0]  sel;
    logic [31:0] wdata;
    logic        dbg;
    logic [1:0]  prv;
    logic        pcv;
    logic [31:0] pc;
    logic        eav;
    logic        st;
    logic [31:0] ea;
    logic [5:0]  exp_pulse;
    logic [3:0]  exp_hit;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic wen, logic [1:0] idx, logic [1:0] sel, logic [31:0] wdata,
                              logic dbg, logic [1:0] prv, logic pcv, logic [31:0] pcx,
                              logic eav, logic st, logic [31:0] eax, logic [5:0] p,
                              logic [3:0] h, logic chk, logic [31:0] rd);
    vec_t v;
    v.wen = wen; v.idx = idx; v.sel = sel; v.wdata = wdata;
    v.dbg = dbg; v.prv = prv; v.pcv = pcv; v.pc = pcx;
    v.eav = eav; v.st = st; v.ea = eax;
    v.exp_pulse = p; v.exp_hit = h; v.chk_rd = chk; v.exp_rd = rd;
    return v;
  endfunction

  function automatic vec_t wr(logic [1:0] idx, logic [1:0] sel, logic [31:0] d, logic [3:0] h,
                              logic [31:0] rd);
    return mk(1'b1, idx, sel, d, 1'b0, 2'd3, 1'b0, 0, 1'b0, 1'b0, 0, P_NONE, h, 1'b1, rd);
  endfunction

  function automatic vec_t fe(logic [1:0] prv, logic [31:0] a, logic [5:0] p, logic [3:0] h);
    return mk(1'b0, 2'd0, 2'd0, 0, 1'b0, prv, 1'b1, a, 1'b0, 1'b0, 0, p, h, 1'b0, 0);
  endfunction

  function automatic vec_t ldv(logic [1:0] prv, logic [31:0] a, logic [5:0] p, logic [3:0] h);
    return mk(1'b0, 2'd0, 2'd0, 0, 1'b0, prv, 1'b0, 0, 1'b1, 1'b0, a, p, h, 1'b0, 0);
  endfunction

  function automatic vec_t stv(logic [1:0] prv, logic [31:0] a, logic [5:0] p, logic [3:0] h);
    return mk(1'b0, 2'd0, 2'd0, 0, 1'b0, prv, 1'b0, 0, 1'b1, 1'b1, a, p, h, 1'b0, 0);
  endfunction

  task automatic checkOutput(input string nm, input logic [5:0] exp_p, input logic [3:0] exp_h,
                             input logic chk_rd, input logic [31:0] exp_rd);
    logic [5:0] act;
    act = {debug_if, debug_ld, debug_st, xcpt_if, xcpt_ld, xcpt_st};
    checks++;
    if (act !== exp_p) begin
      failures++;
      $display("[TB] FAIL %s pulses {dif,dld,dst,xif,xld,xst} got=%b want=%b", nm, act, exp_p);
    end
    checks++;
    if (hit_vec !== exp_h) begin
      failures++;
      $display("[TB] FAIL %s hit_vec got=%b want=%b", nm, hit_vec, exp_h);
    end
    if (chk_rd) begin
      checks++;
      if (cfg_rdata !== exp_rd) begin
        failures++;
        $display("[TB] FAIL %s cfg_rdata got=%h want=%h", nm, cfg_rdata, exp_rd);
      end
    end
  endtask

  // Drives one cycle of inputs, lets the edge pass and checks the registered result.
  task automatic applyStimulus(input vec_t v, input string nm);
    cfg_wen = v.wen; cfg_idx = v.idx; cfg_sel = v.sel; cfg_wdata = v.wdata;
    status_debug = v.dbg; status_prv = v.prv;
    pc_valid = v.pcv; pc = v.pc;
    ea_valid = v.eav; ea_is_store = v.st; ea = v.ea;
    @(posedge clock);
    #1;
    checkOutput(nm, v.exp_pulse, v.exp_hit, v.chk_rd, v.exp_rd);
  endtask

  logic [11:0] m_ctrl [NBP];
  logic [31:0] m_addr [NBP];
  logic [7:0]  m_cnt  [NBP];
  logic [3:0]  m_hit;

  task automatic model_clear();
    for (int i = 0; i < NBP; i++) begin
      m_ctrl[i] = '0; m_addr[i] = '0; m_cnt[i] = '0;
    end
    m_hit = '0;
  endtask

  function automatic bit addr_ok(int k, logic [31:0] a);
    longint unsigned lo, size, av, tv;
    int ones;
    av = 64'(a);
    tv = 64'(m_addr[k]);
    case (m_ctrl[k][8:7])
      2'd0: return av == tv;
      2'd1: begin
        ones = 0;
        while (ones < MASKMAX - 1 && m_addr[k][ones]) ones++;
        size = 64'd1 << (ones + 1);
        lo   = tv & ~(size - 64'd1);
        return (av >= lo) && (av < lo + size);
      end
      2'd2: return av >= tv;
      default: return av < tv;
    endcase
  endfunction

  // t: 0 = fetch, 1 = load, 2 = store
  function automatic bit raw(int k, int t, vec_t v);
    bit priv_on, type_on, valid;
    logic [31:0] a;
    priv_on = ((m_ctrl[k] >> (3 + int'(v.prv))) & 12'd1) != 12'd0;
    type_on = (t == 0) ? m_ctrl[k][2] : (t == 1) ? m_ctrl[k][0] : m_ctrl[k][1];
    valid   = (t == 0) ? v.pcv : (v.eav && ((t == 2) == v.st));
    a       = (t == 0) ? v.pc : v.ea;
    return !v.dbg && priv_on && type_on && valid && addr_ok(k, a);
  endfunction

  function automatic logic [31:0] model_read(logic [1:0] idx, logic [1:0] sel);
    case (sel)
      2'd0: return {20'd0, m_ctrl[idx]};
      2'd1: return m_addr[idx];
      2'd2: return {24'd0, m_cnt[idx]};
      default: return 32'd0;
    endcase
  endfunction

  // Predicts the next-cycle outputs for v, advances the model and fills the expectations.
  task automatic model_step(inout vec_t v);
    bit dbg_t [3];
    bit xc_t  [3];
    bit matched [3];
    bit any_m, all_m;
    logic [3:0] fired;
    int start;
    fired = '0;
    for (int t = 0; t < 3; t++) begin dbg_t[t] = 0; xc_t[t] = 0; end
    for (int j = 0; j < NBP; j++) begin
      if (j == NBP - 1 || !m_ctrl[j][9]) begin
        start = j;
        while (start > 0 && m_ctrl[start-1][9]) start--;
        any_m = 0;
        for (int t = 0; t < 3; t++) begin
          all_m = 1;
          for (int k = start; k <= j; k++) all_m = all_m && raw(k, t, v);
          matched[t] = all_m;
          any_m = any_m || all_m;
        end
        if (any_m) begin
          if (m_ctrl[j][11] && m_cnt[j] != 0) begin
            m_cnt[j] = m_cnt[j] - 8'd1;
          end else begin
            fired[j] = 1'b1;
            for (int t = 0; t < 3; t++)
              if (matched[t]) begin
                if (m_ctrl[j][10]) dbg_t[t] = 1; else xc_t[t] = 1;
              end
          end
        end
      end
    end
    v.exp_pulse = {dbg_t[0], dbg_t[1], dbg_t[2],
                   xc_t[0] && !dbg_t[0], xc_t[1] && !dbg_t[1], xc_t[2] && !dbg_t[2]};
    m_hit = m_hit | fired;
    if (v.wen) begin
      case (v.sel)
        2'd0: begin m_ctrl[v.idx] = v.wdata[11:0]; m_hit[v.idx] = 1'b0; end
        2'd1: m_addr[v.idx] = v.wdata;
        2'd2: m_cnt[v.idx]  = v.wdata[7:0];
        default: ;
      endcase
    end
    v.exp_hit = m_hit;
    v.chk_rd  = 1'b1;
    v.exp_rd  = model_read(v.idx, v.sel);
  endtask

  initial begin
    vec_t v;

    tbl.push_back(wr(0, 1, 32'h1000, 4'b0000, 32'h1000));
    tbl.push_back(wr(0, 0, 32'h044,  4'b0000, 32'h044));
    tbl.push_back(fe(3, 32'h1000, P_XIF,  4'b0001));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, P_NONE, 4'b0001, 0, 0));
    tbl.push_back(fe(3, 32'h1004, P_NONE, 4'b0001));
    tbl.push_back(wr(3, 1, 32'h2003, 4'b0001, 32'h2003));
    tbl.push_back(wr(3, 0, 32'h089,  4'b0001, 32'h089));
    tbl.push_back(ldv(0, 32'h2000, P_XLD,  4'b1001));
    tbl.push_back(ldv(0, 32'h2007, P_XLD,  4'b1001));
    tbl.push_back(ldv(0, 32'h2008, P_NONE, 4'b1001));
    tbl.push_back(ldv(0, 32'h1FFF, P_NONE, 4'b1001));
    tbl.push_back(ldv(3, 32'h2004, P_NONE, 4'b1001));
    tbl.push_back(stv(0, 32'h2004, P_NONE, 4'b1001));
    tbl.push_back(mk(1, 0, 0, 32'h044, 0, 3, 1, 32'h1000, 0, 0, 0, P_XIF, 4'b1000, 1, 32'h044));
    tbl.push_back(wr(0, 0, 32'h0, 4'b1000, 32'h0));
    tbl.push_back(wr(3, 0, 32'h0, 4'b0000, 32'h0));
    tbl.push_back(wr(1, 1, 32'h3000,     4'b0000, 32'h3000));
    tbl.push_back(wr(1, 0, 32'hFFFFF342, 4'b0000, 32'h342));
    tbl.push_back(wr(2, 1, 32'h3100,     4'b0000, 32'h3100));
    tbl.push_back(wr(2, 0, 32'h5C2,      4'b0000, 32'h5C2));
    tbl.push_back(stv(3, 32'h3050, P_DST,  4'b0100));
    tbl.push_back(stv(3, 32'h3200, P_NONE, 4'b0100));
    tbl.push_back(ldv(3, 32'h3050, P_NONE, 4'b0100));
    tbl.push_back(stv(3, 32'h3000, P_DST,  4'b0100));
    tbl.push_back(stv(3, 32'h2FFF, P_NONE, 4'b0100));
    tbl.push_back(stv(3, 32'h3100, P_NONE, 4'b0100));
    tbl.push_back(wr(1, 0, 32'h0, 4'b0100, 32'h0));
    tbl.push_back(wr(2, 0, 32'h0, 4'b0000, 32'h0));
    tbl.push_back(wr(0, 2, 32'h2,   4'b0000, 32'h2));
    tbl.push_back(wr(0, 0, 32'h844, 4'b0000, 32'h844));
    tbl.push_back(mk(0, 0, 2, 0, 0, 3, 1, 32'h1000, 0, 0, 0, P_NONE, 4'b0000, 1, 32'h1));
    tbl.push_back(mk(0, 0, 2, 0, 0, 3, 1, 32'h1000, 0, 0, 0, P_NONE, 4'b0000, 1, 32'h0));
    tbl.push_back(mk(0, 0, 2, 0, 0, 3, 1, 32'h1000, 0, 0, 0, P_XIF,  4'b0001, 1, 32'h0));
    tbl.push_back(mk(0, 0, 2, 0, 0, 3, 1, 32'h1000, 0, 0, 0, P_XIF,  4'b0001, 1, 32'h0));
    tbl.push_back(wr(0, 2, 32'h1, 4'b0001, 32'h1));
    tbl.push_back(mk(1, 0, 2, 32'h5, 0, 3, 1, 32'h1000, 0, 0, 0, P_NONE, 4'b0001, 1, 32'h5));
    tbl.push_back(mk(0, 0, 2, 0,     0, 3, 1, 32'h1000, 0, 0, 0, P_NONE, 4'b0001, 1, 32'h4));
    tbl.push_back(wr(0, 0, 32'h0, 4'b0000, 32'h0));
    tbl.push_back(wr(1, 1, 32'h4000, 4'b0000, 32'h4000));
    tbl.push_back(wr(1, 0, 32'h041,  4'b0000, 32'h041));
    tbl.push_back(wr(2, 1, 32'h4000, 4'b0000, 32'h4000));
    tbl.push_back(wr(2, 0, 32'h441,  4'b0000, 32'h441));
    tbl.push_back(ldv(3, 32'h4000, P_DLD, 4'b0110));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 1, 0, 32'h4000, P_NONE, 4'b0110, 0, 0));
    tbl.push_back(fe(3, 32'h4000, P_NONE, 4'b0110));
    tbl.push_back(wr(1, 3, 32'hFFFF, 4'b0110, 32'h0));
    tbl.push_back(wr(2, 0, 32'h0,    4'b0010, 32'h0));
    tbl.push_back(ldv(3, 32'h4000, P_XLD, 4'b0010));
    tbl.push_back(wr(0, 1, 32'h1000, 4'b0010, 32'h1000));
    tbl.push_back(wr(0, 0, 32'h044,  4'b0010, 32'h044));
    tbl.push_back(fe(3, 32'h1000, P_XIF, 4'b0011));

    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_held", P_NONE, 4'b0000, 1'b1, 32'h0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("reset_released", P_NONE, 4'b0000, 1'b1, 32'h0);

    foreach (tbl[i]) applyStimulus(tbl[i], $sformatf("vec%0d", i));

    // Async reset while the last fetch match keeps re-firing every cycle.
    #2 reset = 1'b0;
    #1;
    cfg_wen = 1'b0;
    checkOutput("async_reset_now", P_NONE, 4'b0000, 1'b0, 32'h0);
    for (int i = 0; i < NBP; i++) begin
      for (int s = 0; s < 3; s++) begin
        cfg_idx = 2'(i);
        cfg_sel = 2'(s);
        #1;
        checkOutput($sformatf("reset_rd_t%0d_s%0d", i, s), P_NONE, 4'b0000, 1'b1, 32'h0);
      end
    end
    @(posedge clock);
    #1;
    checkOutput("reset_edge", P_NONE, 4'b0000, 1'b0, 32'h0);
    reset = 1'b1;
    model_clear();

    for (int n = 0; n < 600; n++) begin
      v = '0;
      v.wen = ($urandom_range(0, 99) < 20);
      v.idx = 2'($urandom_range(0, 3));
      v.sel = 2'($urandom_range(0, 3));
      case (v.sel)
        2'd0:    v.wdata = $urandom;
        2'd1:    v.wdata = 32'($urandom_range(0, 63));
        2'd2:    v.wdata = 32'($urandom_range(0, 3));
        default: v.wdata = $urandom;
      endcase
      v.dbg = ($urandom_range(0, 15) == 0);
      v.prv = 2'($urandom_range(0, 3));
      v.pcv = 1'($urandom_range(0, 1));
      v.pc  = 32'($urandom_range(0, 63));
      v.eav = 1'($urandom_range(0, 1));
      v.st  = 1'($urandom_range(0, 1));
      v.ea  = 32'($urandom_range(0, 63));
      model_step(v);
      applyStimulus(v, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/breakpoint_unit_multi.md
Name: breakpoint_unit_multi

Overview:
- Next-generation hardware breakpoint unit with NBP triggers held in internal config registers, loaded through a CSR-style write port.
- Adds ranged/NAPOT/exact address matching, chaining of adjacent triggers, per-trigger hit countdown, sticky hit status and registered one-cycle exception/debug outputs.
- Sits beside the CSR file; fetch and LSU stages present pc/ea with valid qualifiers.

Parameters:
- XLEN, 32, address/data width.
- NBP, 4, number of triggers (1..16).
- MASKMAX, 4, max NAPOT low-order mask bits (1..XLEN-1).
- CNT_W, 8, width of per-trigger hit countdown.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_wen  in  1  config write strobe.
- cfg_idx  in  max(1,$clog2(NBP))  trigger select; values >= NBP ignored.
- cfg_sel  in  2  0=control, 1=address, 2=count, 3=reserved (write ignored).
- cfg_wdata  in  XLEN  write data.
- cfg_rdata  out  XLEN  combinational readback of the selected register; zero for invalid idx or sel.
- status_debug  in  1  core in debug mode; suppresses all matching.
- status_prv  in  2  privilege level 0=U, 1=S, 2=H, 3=M.
- pc_valid  in  1  fetch address valid.
- pc  in  XLEN  fetch address.
- ea_valid  in  1  data access valid.
- ea_is_store  in  1  1=store, 0=load.
- ea  in  XLEN  data effective address.
- xcpt_if / xcpt_ld / xcpt_st  out  1 each  breakpoint exception pulses.
- debug_if / debug_ld / debug_st  out  1 each  debug-entry pulses.
- hit_vec  out  NBP  sticky per-trigger hit flags.

Behaviour:
- Control register layout: [0] r, [1] w, [2] x, [3] u, [4] s, [5] h, [6] m, [8:7] tmatch, [9] chain, [10] action, [11] count_en. Other bits read as 0.
- Privilege enable: bit (3+status_prv) of control.
- tmatch semantics:
  - 0 = exact compare.
  - 1 = NAPOT: the mask covers low address bits up to and including the first 0 in addr[MASKMAX-2:0], bit 0 always masked. Compare ~a|mask against ~addr|mask.
  - 2 = unsigned a >= addr.
  - 3 = unsigned a < addr.
- Raw match for trigger i and access type t:
  - Requires: status_debug=0, privilege enabled, the type-enable bit set (x for if, r for ld, w for st), the qualifying valid high, and the address test true.
  - a = pc for if, ea for ld/st.
- Chaining:
  - A group is a maximal run i..j where chain=1 on i..j-1 and chain=0 on j. chain on trigger NBP-1 is treated as 0.
  - The group matches for type t only if every member raw-matches t in the same cycle.
  - Result is attributed to terminal trigger j. Non-terminal members never fire on their own.
- Countdown, on terminal j only:
  - If count_en=1 and count!=0, a group match decrements count by 1 at the clock edge and does not fire.
  - If count==0 or count_en=0, a group match fires. Count saturates at 0.
  - One decrement per cycle even if if/ld/st all match together.
- Firing:
  - Registered, so outputs assert exactly 1 cycle after the qualifying access and last 1 cycle.
  - debug_t = OR over firing terminals with action=1.
  - xcpt_t = OR over firing terminals with action=0, and only when debug_t is not also asserted (debug has priority).
- hit_vec[j] sets on the cycle after a fire. It clears only on a cfg write to control of trigger j. A write and a set in the same cycle: the write wins (cleared).
- Write vs. internal update: a cfg write to count in the same cycle as a decrement wins. Writes take effect for matches on the following cycle.
- Reset: all control/address/count = 0 (all triggers disabled), hit_vec = 0, all six pulse outputs = 0. Asserting reset mid-access drops any pending pulse.

Test Plan:
- Trigger0 control x,m (0x044), address 0x1000, prv=3; pc_valid with pc=0x1000 -> xcpt_if=1 next cycle only, hit_vec=0001; pc=0x1004 -> no output.
- NAPOT (tmatch=1) address 0x2003, r, u; ea load at 0x2000..0x2007 -> xcpt_ld each. 0x2008 -> none. Same hit with prv=3 and m=0 -> none.
- Trigger1 (chain=1, ge 0x3000, w) with trigger2 (lt 0x3100, w, action=1); store at 0x3050 -> debug_st=1, hit_vec=0100. Store at 0x3200 -> none. Load at 0x3050 -> none.
- count_en=1, count=2 on exact pc match; three matching fetches -> pulses only on the third, count reads 0, then fires every match.
- Two terminals, one action=0 and one action=1, hit the same ld -> debug_ld=1, xcpt_ld=0. status_debug=1 on the same stimulus -> no outputs, counts unchanged.
- Async reset low mid-run with a pending match -> outputs and hit_vec 0 immediately, cfg_rdata reads 0 for all registers.
